asg_dbuf_swap_ctrl: RTL

Ping-pong ownership controller for one channel of the double-buffered arbitrary signal generator table. The DAC read pointer replays the "active" half of the waveform RAM while software refills the "back" half over the system bus. This block decides when the halves swap: at period end, on trigger, or immediately. It locks the back half once it is committed, and it detects and counts underruns. It sits between the ASG register bank and the table read/write address muxes, with one instance per channel.

---
 rtl/asg_dbuf_swap_ctrl_if.sv | 43 ++++
 rtl/asg_dbuf_swap_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/asg_dbuf_swap_ctrl_if.sv
// rtl/asg_dbuf_swap_ctrl_if.sv - control/status bundle between ASG register bank and swap controller
// Optional mute_o is present only when ASG_DBUF_UNDERRUN_MUTE_EN is defined.
interface asg_dbuf_swap_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cfg_en_i;
  logic [1:0]       cfg_mode_i;
  logic             buf_fill_i;
  logic             buf_abort_i;
  logic             rd_wrap_i;
  logic             trig_i;
  logic             sts_clr_i;
  logic             act_sel_o;
  logic             wr_sel_o;
  logic             wr_lock_o;
  logic             pending_o;
  logic             swap_o;
  logic             underrun_o;
  logic             fill_ovr_o;
  logic [CNT_W-1:0] underrun_cnt_o;
  logic             irq_o;
`ifdef ASG_DBUF_UNDERRUN_MUTE_EN
  logic             mute_o;
`endif

  modport master (
    output cfg_en_i, cfg_mode_i, buf_fill_i, buf_abort_i, rd_wrap_i, trig_i, sts_clr_i,
    input  act_sel_o, wr_sel_o, wr_lock_o, pending_o, swap_o, underrun_o, fill_ovr_o,
           underrun_cnt_o, irq_o
`ifdef ASG_DBUF_UNDERRUN_MUTE_EN
    , input mute_o
`endif
  );

  modport slave (
    input  cfg_en_i, cfg_mode_i, buf_fill_i, buf_abort_i, rd_wrap_i, trig_i, sts_clr_i,
    output act_sel_o, wr_sel_o, wr_lock_o, pending_o, swap_o, underrun_o, fill_ovr_o,
           underrun_cnt_o, irq_o
`ifdef ASG_DBUF_UNDERRUN_MUTE_EN
    , output mute_o
`endif
  );
endinterface

// File: rtl/asg_dbuf_swap_ctrl.sv
// rtl/asg_dbuf_swap_ctrl.sv - ping-pong ownership controller for one ASG channel table
// Optional feature macro: ASG_DBUF_UNDERRUN_MUTE_EN (adds mute_o after an underrun).
module asg_dbuf_swap_ctrl #(
  parameter int CNT_W    = 16,
  parameter bit INIT_SEL = 1'b0
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rst_i,
  asg_dbuf_swap_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMPTY = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t           state_q;
  logic             act_sel_q;
  logic             wr_lock_q;
  logic             pending_q;
  logic             swap_q;
  logic             underrun_q;
  logic             fill_ovr_q;
  logic             irq_q;
  logic [CNT_W-1:0] cnt_q;
`ifdef ASG_DBUF_UNDERRUN_MUTE_EN
  logic             mute_q;
`endif

  logic             swap_evt_d;
  logic             und_base_d;
  logic             ovr_base_d;
  logic [CNT_W-1:0] cnt_base_d;

  // Clear takes effect before any same-cycle set, so flag/count bases are post-clear.
  always_comb begin
    swap_evt_d = 1'b0;
    case (bus.cfg_mode_i)
      2'd1:    swap_evt_d = bus.trig_i;
      2'd2:    swap_evt_d = 1'b1;
      default: swap_evt_d = bus.rd_wrap_i;
    endcase
    und_base_d = bus.sts_clr_i ? 1'b0 : underrun_q;
    ovr_base_d = bus.sts_clr_i ? 1'b0 : fill_ovr_q;
    cnt_base_d = bus.sts_clr_i ? '0   : cnt_q;
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q    <= IDLE;
      act_sel_q  <= INIT_SEL;
      wr_lock_q  <= 1'b0;
      pending_q  <= 1'b0;
      swap_q     <= 1'b0;
      underrun_q <= 1'b0;
      fill_ovr_q <= 1'b0;
      irq_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef ASG_DBUF_UNDERRUN_MUTE_EN
      mute_q     <= 1'b0;
`endif
    end else begin
      swap_q     <= 1'b0;
      irq_q      <= 1'b0;
      underrun_q <= und_base_d;
      fill_ovr_q <= ovr_base_d;
      cnt_q      <= cnt_base_d;
      if (!bus.cfg_en_i) begin
        // Disabling drops any committed half without swapping.
        state_q   <= IDLE;
        wr_lock_q <= 1'b0;
        pending_q <= 1'b0;
`ifdef ASG_DBUF_UNDERRUN_MUTE_EN
        mute_q    <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= EMPTY;
          end
          EMPTY: begin
            if (bus.rd_wrap_i) begin
              underrun_q <= 1'b1;
              irq_q      <= ~und_base_d;
              if (cnt_base_d != '1) cnt_q <= cnt_base_d + 1'b1;
`ifdef ASG_DBUF_UNDERRUN_MUTE_EN
              mute_q     <= 1'b1;
`endif
            end
            if (bus.buf_fill_i) begin
              state_q   <= ARMED;
              wr_lock_q <= 1'b1;
              pending_q <= 1'b1;
            end
          end
          ARMED: begin
            if (bus.buf_fill_i) fill_ovr_q <= 1'b1;
            if (swap_evt_d) begin
              state_q   <= EMPTY;
              act_sel_q <= ~act_sel_q;
              swap_q    <= 1'b1;
              irq_q     <= 1'b1;
              wr_lock_q <= 1'b0;
              pending_q <= 1'b0;
`ifdef ASG_DBUF_UNDERRUN_MUTE_EN
              mute_q    <= 1'b0;
`endif
            end else if (bus.buf_abort_i) begin
              state_q   <= EMPTY;
              wr_lock_q <= 1'b0;
              pending_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= IDLE;
            wr_lock_q <= 1'b0;
            pending_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.act_sel_o      = act_sel_q;
  assign bus.wr_sel_o       = ~act_sel_q;
  assign bus.wr_lock_o      = wr_lock_q;
  assign bus.pending_o      = pending_q;
  assign bus.swap_o         = swap_q;
  assign bus.underrun_o     = underrun_q;
  assign bus.fill_ovr_o     = fill_ovr_q;
  assign bus.underrun_cnt_o = cnt_q;
  assign bus.irq_o          = irq_q;
`ifdef ASG_DBUF_UNDERRUN_MUTE_EN
  assign bus.mute_o         = mute_q;
`endif

endmodule
